arp_tx: RTL

//  Byte-serial ARP packet generator: builds 28-byte ARP payloads (reply or request) and streams them to the MAC TX path.

---
 rtl/arp_tx_if.sv | 19 +
 rtl/arp_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arp_tx_if.sv
// Byte stream from the ARP generator to the MAC TX path,
// with the frame destination MAC riding alongside.
interface arp_tx_if;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [7:0]  tx_data;
  logic [47:0] eth_dest_mac;

  modport master (
    output tx_valid, tx_data, tx_last, eth_dest_mac,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, tx_last, eth_dest_mac,
    output tx_ready
  );
endinterface

// File: rtl/arp_tx.sv
// ARP reply/request generator: streams 28-byte ARP payloads
// byte-serially, with a 1-deep slot for deferred requests.
module arp_tx #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_02_03,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_0A
) (
  input  logic        i_sys_clk,
  input  logic        i_rst,
  input  logic        i_reply_req,
  input  logic [31:0] i_reply_ip,
  input  logic [47:0] i_reply_mac,
  input  logic        i_request_req,
  input  logic [31:0] i_request_ip,
  arp_tx_if.master    tx,
  output logic        o_arp_tx_busy,
  output logic        o_req_dropped
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rep_q, rep_d;
  logic [31:0] ip_q, ip_d;
  logic [47:0] mac_q, mac_d;
  logic        pend_q, pend_d;
  logic [31:0] pip_q, pip_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;
  logic [7:0]  data_q, data_d;
  logic [47:0] dest_q, dest_d;

  logic        start;
  logic        s_rep;
  logic [31:0] s_ip;
  logic [47:0] s_mac;
  logic [4:0]  nxt;

  function automatic logic [7:0] arp_byte(
    input logic [4:0]  idx,
    input logic        rep,
    input logic [47:0] tha,
    input logic [31:0] tpa
  );
    logic [7:0] b;
    int k;
    k = int'(idx);
    b = 8'h00;
    unique case (1'b1)
      (k == 1):           b = 8'h01;
      (k == 2):           b = 8'h08;
      (k == 4):           b = 8'h06;
      (k == 5):           b = 8'h04;
      (k == 7):           b = rep ? 8'h02 : 8'h01;
      (k >= 8 && k < 14): b = LOCAL_MAC[8*(13-k) +: 8];
      (k >= 14 && k < 18): b = LOCAL_IP[8*(17-k) +: 8];
      (k >= 18 && k < 24): b = tha[8*(23-k) +: 8];
      (k >= 24 && k < 28): b = tpa[8*(27-k) +: 8];
      default:            b = 8'h00;
    endcase
    return b;
  endfunction

  assign nxt = cnt_q + 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    ip_d    = ip_q;
    mac_d   = mac_q;
    pend_d  = pend_q;
    pip_d   = pip_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    data_d  = data_q;
    dest_d  = dest_q;
    drop_d  = 1'b0;
    start   = 1'b0;
    s_rep   = 1'b0;
    s_ip    = '0;
    s_mac   = '0;
    unique case (state_q)
      IDLE: begin
        if (i_reply_req) begin
          start = 1'b1;
          s_rep = 1'b1;
          s_ip  = i_reply_ip;
          s_mac = i_reply_mac;
          if (i_request_req) begin
            if (!pend_q) begin
              pend_d = 1'b1;
              pip_d  = i_request_ip;
            end else begin
              drop_d = 1'b1;
            end
          end
        end else if (pend_q) begin
          // Slot drains now; a fresh request can refill it at once
          start  = 1'b1;
          s_ip   = pip_q;
          pend_d = i_request_req;
          if (i_request_req) pip_d = i_request_ip;
        end else if (i_request_req) begin
          start = 1'b1;
          s_ip  = i_request_ip;
        end
      end
      SEND: begin
        if (i_reply_req) drop_d = 1'b1;
        if (i_request_req) begin
          if (!pend_q) begin
            pend_d = 1'b1;
            pip_d  = i_request_ip;
          end else begin
            drop_d = 1'b1;
          end
        end
        if (valid_q && tx.tx_ready) begin
          if (cnt_q == 5'd27) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d  = nxt;
            data_d = arp_byte(nxt, rep_q, mac_q, ip_q);
            last_d = (nxt == 5'd27);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = SEND;
      cnt_d   = '0;
      rep_d   = s_rep;
      ip_d    = s_ip;
      mac_d   = s_mac;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      last_d  = 1'b0;
      data_d  = 8'h00;
      dest_d  = s_rep ? s_mac : {48{1'b1}};
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      ip_q    <= '0;
      mac_q   <= '0;
      pend_q  <= 1'b0;
      pip_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      ip_q    <= ip_d;
      mac_q   <= mac_d;
      pend_q  <= pend_d;
      pip_q   <= pip_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
    end
  end

  assign tx.tx_valid     = valid_q;
  assign tx.tx_data      = data_q;
  assign tx.tx_last      = last_q;
  assign tx.eth_dest_mac = dest_q;
  assign o_arp_tx_busy   = busy_q;
  assign o_req_dropped   = drop_q;

endmodule
